ram_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between three requesters:
  - the RV32 instruction fetch port (I);
  - the RV32 load/store port (D);
  - a boot loader write port (L) that fills program memory over an external link.
- Fixed-priority arbitration with a pipelined valid/gnt/rvalid handshake and 1-cycle RAM read latency.
- Sits between the RV32 core and a single-port replacement for the current dual-port RAM.

---
 rtl/ram_port_arbiter_if.sv | 53 +++++
 rtl/ram_port_arbiter.sv | 98 +++++++++
 tb/tb_ram_port_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side signals of the shared single-port RAM arbiter.
// slave = arbiter view, master = requesters plus RAM (the environment).
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_AW     = 10
);
    logic                  i_req_i;
    logic [ADDR_WIDTH-1:0] i_addr_i;
    logic                  i_gnt_o;
    logic                  i_rvalid_o;
    logic [DATA_WIDTH-1:0] i_rdata_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic                  d_gnt_o;
    logic                  d_rvalid_o;
    logic [DATA_WIDTH-1:0] d_rdata_o;

    logic                  l_req_i;
    logic [ADDR_WIDTH-1:0] l_addr_i;
    logic [DATA_WIDTH-1:0] l_wdata_i;
    logic                  l_gnt_o;

    logic [RAM_AW-1:0]     ram_addr_o;
    logic                  ram_we_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;

    modport slave (
        input  i_req_i, i_addr_i,
        output i_gnt_o, i_rvalid_o, i_rdata_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        input  l_req_i, l_addr_i, l_wdata_i,
        output l_gnt_o,
        output ram_addr_o, ram_we_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport master (
        output i_req_i, i_addr_i,
        input  i_gnt_o, i_rvalid_o, i_rdata_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        output l_req_i, l_addr_i, l_wdata_i,
        input  l_gnt_o,
        input  ram_addr_o, ram_we_o, ram_wdata_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Fixed-priority (L > D > I) arbiter sharing one single-port sync RAM; grant is combinational, read data 1 cycle later.
// Optional ARB_STARVE_GUARD_EN: after STARVE_LIMIT denied fetch cycles, I is placed ahead of D (L still wins).
module ram_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int RAM_AW       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ram_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } resp_e;

    resp_e                 resp_q, resp_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  l_gnt, d_gnt, i_gnt;
    logic                  starve_force;

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = '0;
        if (bus.i_req_i && !i_gnt)
            starve_cnt_d = (starve_cnt_q == 3'd7) ? 3'd7 : starve_cnt_q + 3'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) starve_cnt_q <= '0;
        else       starve_cnt_q <= starve_cnt_d;
    end

    assign starve_force = bus.i_req_i && (int'(starve_cnt_q) >= STARVE_LIMIT);
`else
    // Without the guard the limit has no meaning; this is constant 0 for any legal limit.
    assign starve_force = (STARVE_LIMIT < 0);
`endif

    always_comb begin
        // Gating with rst_i makes every output drop asynchronously while reset is held.
        l_gnt = !rst_i && bus.l_req_i;
        d_gnt = !rst_i && bus.d_req_i && !bus.l_req_i && !starve_force;
        i_gnt = !rst_i && bus.i_req_i && !bus.l_req_i && (!bus.d_req_i || starve_force);

        bus.ram_addr_o  = '0;
        bus.ram_we_o    = 1'b0;
        bus.ram_wdata_o = '0;
        if (l_gnt) begin
            bus.ram_addr_o  = bus.l_addr_i[RAM_AW+1:2];
            bus.ram_we_o    = 1'b1;
            bus.ram_wdata_o = bus.l_wdata_i;
        end else if (d_gnt) begin
            bus.ram_addr_o  = bus.d_addr_i[RAM_AW+1:2];
            bus.ram_we_o    = bus.d_we_i;
            bus.ram_wdata_o = bus.d_we_i ? bus.d_wdata_i : '0;
        end else if (i_gnt) begin
            bus.ram_addr_o  = bus.i_addr_i[RAM_AW+1:2];
        end

        resp_d = NONE;
        if (i_gnt)                      resp_d = RESP_I;
        else if (d_gnt && !bus.d_we_i)  resp_d = RESP_D;

        bus.l_gnt_o    = l_gnt;
        bus.d_gnt_o    = d_gnt;
        bus.i_gnt_o    = i_gnt;
        bus.i_rvalid_o = (resp_q == RESP_I);
        bus.d_rvalid_o = (resp_q == RESP_D);
        // RAM data passes straight through on the response cycle, otherwise the last value is held.
        bus.i_rdata_o  = bus.i_rvalid_o ? bus.ram_rdata_i : i_rdata_q;
        bus.d_rdata_o  = bus.d_rvalid_o ? bus.ram_rdata_i : d_rdata_q;
        i_rdata_d      = bus.i_rdata_o;
        d_rdata_d      = bus.d_rdata_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_q    <= NONE;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            resp_q    <= resp_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    wire unused_addr_bits = &{1'b0,
                              bus.i_addr_i[1:0], bus.i_addr_i[ADDR_WIDTH-1:RAM_AW+2],
                              bus.d_addr_i[1:0], bus.d_addr_i[ADDR_WIDTH-1:RAM_AW+2],
                              bus.l_addr_i[1:0], bus.l_addr_i[ADDR_WIDTH-1:RAM_AW+2]};
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter against a cycle-level reference model.
module tb_ram_port_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int RAW   = 10;
    localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_AW(RAW)) bus ();

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_AW(RAW), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Behavioural single-port RAM: request captured mid-cycle, applied/read on the next rising edge.
    logic [DW-1:0]  ram_mem [0:1023];
    logic [DW-1:0]  ram_rd    = '0;
    logic           cap_we    = 1'b0;
    logic [RAW-1:0] cap_addr  = '0;
    logic [DW-1:0]  cap_wdata = '0;
    always @(negedge clk) begin
        cap_we    <= bus.ram_we_o;
        cap_addr  <= bus.ram_addr_o;
        cap_wdata <= bus.ram_wdata_o;
    end
    always @(posedge clk) begin
        if (cap_we) ram_mem[cap_addr] <= cap_wdata;
        ram_rd <= ram_mem[cap_addr];
    end
    assign bus.ram_rdata_i = ram_rd;

    // Reference model state.
    logic [31:0] mmem [0:1023];
    int          pend;          // 0 none, 1 fetch, 2 load
    logic [31:0] exp_irdata, exp_drdata;
    int          starve;
    int          last_g;        // 0 none, 1 I, 2 D, 3 L
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend       = 0;
        exp_irdata = '0;
        exp_drdata = '0;
        starve     = 0;
        last_g     = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        logic [3:0]  w;
        r = $urandom();
        w = 4'($urandom_range(0, 15));
        return {r[31:12], 6'b0, w, r[1:0]};
    endfunction

    // One arbitration cycle: check grant/RAM outputs, advance the model, check the response after the edge.
    task automatic step();
        int          g, new_pend;
        logic [31:0] a, wd, npdata;
        logic        we;
        int          word;
        #1;
        if (bus.l_req_i)                                  g = 3;
        else if (GUARD && bus.i_req_i && starve >= LIMIT) g = 1;
        else if (bus.d_req_i)                             g = 2;
        else if (bus.i_req_i)                             g = 1;
        else                                              g = 0;
        check("l_gnt", bus.l_gnt_o, g == 3);
        check("d_gnt", bus.d_gnt_o, g == 2);
        check("i_gnt", bus.i_gnt_o, g == 1);
        a    = (g == 3) ? bus.l_addr_i : (g == 2) ? bus.d_addr_i : (g == 1) ? bus.i_addr_i : 32'd0;
        word = int'((a / 4) % 1024);
        we   = (g == 3) || (g == 2 && bus.d_we_i);
        wd   = (g == 3) ? bus.l_wdata_i : (we ? bus.d_wdata_i : 32'd0);
        check("ram_addr",  bus.ram_addr_o,  word);
        check("ram_we",    bus.ram_we_o,    we);
        check("ram_wdata", bus.ram_wdata_o, wd);
        new_pend = (g == 1) ? 1 : (g == 2 && !bus.d_we_i) ? 2 : 0;
        npdata   = mmem[word];
        if (we) mmem[word] = wd;
        if (bus.i_req_i && g != 1) starve = (starve < 7) ? starve + 1 : 7;
        else                       starve = 0;
        last_g = g;
        @(posedge clk);
        #1;
        pend = new_pend;
        if (pend == 1) exp_irdata = npdata;
        if (pend == 2) exp_drdata = npdata;
        check("i_rvalid", bus.i_rvalid_o, pend == 1);
        check("d_rvalid", bus.d_rvalid_o, pend == 2);
        check("i_rdata",  bus.i_rdata_o,  exp_irdata);
        check("d_rdata",  bus.d_rdata_o,  exp_drdata);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i_gnt"},    bus.i_gnt_o,     0);
        check({tag, "_d_gnt"},    bus.d_gnt_o,     0);
        check({tag, "_l_gnt"},    bus.l_gnt_o,     0);
        check({tag, "_i_rvalid"}, bus.i_rvalid_o,  0);
        check({tag, "_d_rvalid"}, bus.d_rvalid_o,  0);
        check({tag, "_i_rdata"},  bus.i_rdata_o,   0);
        check({tag, "_d_rdata"},  bus.d_rdata_o,   0);
        check({tag, "_ram_we"},   bus.ram_we_o,    0);
        check({tag, "_ram_addr"}, bus.ram_addr_o,  0);
        check({tag, "_ram_wd"},   bus.ram_wdata_o, 0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] fetch_exp [3];
        fetch_exp = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 1024; i++) begin
            v = $urandom();
            ram_mem[i] = v;
            mmem[i]    = v;
        end
        for (int i = 0; i < 3; i++) begin
            ram_mem[i] = fetch_exp[i];
            mmem[i]    = fetch_exp[i];
        end
        bus.i_req_i = 1'b0; bus.i_addr_i = '0;
        bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
        bus.l_req_i = 1'b0; bus.l_addr_i = '0; bus.l_wdata_i = '0;
        model_reset();

        // Reset state, with requests present to show gating.
        #1 rst = 1'b1;
        bus.i_req_i = 1'b1;
        bus.d_req_i = 1'b1;
        #2 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.i_req_i = 1'b0;
        bus.d_req_i = 1'b0;

        // Back-to-back fetches.
        for (int k = 0; k < 3; k++) begin
            bus.i_req_i  = 1'b1;
            bus.i_addr_i = 32'(k * 4);
            step();
            check("fetch_data", bus.i_rdata_o, fetch_exp[k]);
        end
        bus.i_req_i = 1'b0;

        // Store beats fetch; fetch follows; load returns stored value.
        bus.i_req_i = 1'b1; bus.i_addr_i = 32'h0C;
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 32'h40; bus.d_wdata_i = 32'd49;
        #1;
        check("st_d_gnt",    bus.d_gnt_o,    1);
        check("st_i_gnt",    bus.i_gnt_o,    0);
        check("st_ram_we",   bus.ram_we_o,   1);
        check("st_ram_addr", bus.ram_addr_o, 16);
        step();
        bus.d_req_i = 1'b0;
        step();
        bus.i_req_i = 1'b0;
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_wdata_i = '0;
        step();
        check("load_back", bus.d_rdata_o, 32'd49);
        bus.d_req_i = 1'b0;

        // All three requesting: L, then D, then I.
        bus.l_req_i = 1'b1; bus.l_addr_i = 32'h80; bus.l_wdata_i = 32'hCAFE_0001;
        bus.d_req_i = 1'b1; bus.d_addr_i = 32'h80;
        bus.i_req_i = 1'b1; bus.i_addr_i = 32'h04;
        #1;
        check("tri_l_gnt", bus.l_gnt_o, 1);
        check("tri_d_gnt", bus.d_gnt_o, 0);
        check("tri_i_gnt", bus.i_gnt_o, 0);
        step();
        bus.l_req_i = 1'b0;
        step();
        check("tri_d_data", bus.d_rdata_o, 32'hCAFE_0001);
        bus.d_req_i = 1'b0;
        step();
        bus.i_req_i = 1'b0;

        // Address wrap.
        bus.i_req_i = 1'b1; bus.i_addr_i = 32'h1004;
        #1 check("wrap_addr", bus.ram_addr_o, 1);
        step();
        bus.i_req_i = 1'b0;

        // D held continuously against I.
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = rand_addr();
        bus.i_req_i = 1'b1; bus.i_addr_i = 32'h08;
        for (int c = 0; c < 8; c++) begin
            #1 check("starve_i_gnt", bus.i_gnt_o, (c == 4) && GUARD);
            step();
            if (last_g == 2) bus.d_addr_i = rand_addr();
        end
        bus.d_req_i = 1'b0; bus.i_req_i = 1'b0;
        step();

        // Reset while a fetch response is outstanding.
        bus.i_req_i = 1'b1; bus.i_addr_i = 32'h08;
        #1 check("rst_fetch_gnt", bus.i_gnt_o, 1);
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(posedge clk);
        #1 check("rst_no_rvalid", bus.i_rvalid_o, 0);
        bus.i_req_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        step();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            if (last_g == 3 || !bus.l_req_i) begin
                bus.l_req_i   = ($urandom_range(0, 99) < 15);
                bus.l_addr_i  = rand_addr();
                bus.l_wdata_i = $urandom();
            end
            if (last_g == 2 || !bus.d_req_i) begin
                bus.d_req_i   = ($urandom_range(0, 99) < 45);
                bus.d_we_i    = 1'($urandom_range(0, 1));
                bus.d_addr_i  = rand_addr();
                bus.d_wdata_i = $urandom();
            end
            if (last_g == 1 || !bus.i_req_i) begin
                bus.i_req_i  = ($urandom_range(0, 99) < 60);
                bus.i_addr_i = rand_addr();
            end
            step();
        end
        bus.l_req_i = 1'b0; bus.d_req_i = 1'b0; bus.i_req_i = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
